// File: rtl/pet_pkg.sv
// Shared constants, FSM state codes and packed-field helper for the pet core.
package pet_pkg;

  localparam int unsigned LEVEL_W_DEF    = 3;
  localparam int unsigned LEVEL_MAX_DEF  = 5;
  localparam int unsigned LOW_THRESH_DEF = 2;
  localparam int unsigned TICK_DIV_MS    = 50000;
  localparam int unsigned PERIOD_W_DEF   = 16;
  localparam int unsigned FIELD_VEC_W    = 512;

  typedef enum logic [1:0] {
    PET_IDLE  = 2'd0,
    PET_SLEEP = 2'd1,
    PET_PLAY  = 2'd2,
    PET_DEAD  = 2'd3
  } pet_state_e;

  // Returns the w-bit field idx of a packed vector (field 0 at the LSB).
  function automatic int unsigned period_field(input logic [FIELD_VEC_W-1:0] vec,
                                               input int unsigned idx,
                                               input int unsigned w);
    logic [FIELD_VEC_W-1:0] shifted;
    logic [31:0]            mask;
    shifted = vec >> (idx * w);
    mask    = 32'((64'd1 << w) - 64'd1);
    return 32'(shifted) & mask;
  endfunction

endpackage

// File: rtl/need_channel.sv
// One need channel: a level register and its period counter with the
// load / halt / refill / recover / decay priority chain.
module need_channel
  import pet_pkg::*;
#(
  parameter int unsigned LEVEL_W    = LEVEL_W_DEF,
  parameter int unsigned LEVEL_MAX  = LEVEL_MAX_DEF,
  parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
  parameter int unsigned DECAY_MS   = 1,
  parameter int unsigned RECOVER_MS = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               halt_i,
  input  logic               load_en_i,
  input  logic [LEVEL_W-1:0] load_level_i,
  input  logic               refill_i,
  input  logic               recover_en_i,
  input  logic               hold_i,
  output logic [LEVEL_W-1:0] level_o
);

  localparam logic [LEVEL_W-1:0]  LVL_MAX    = LEVEL_W'(LEVEL_MAX);
  localparam logic [PERIOD_W-1:0] DECAY_LAST = PERIOD_W'(DECAY_MS - 1);
  localparam logic [PERIOD_W-1:0] REC_LAST   = PERIOD_W'(RECOVER_MS - 1);

  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                rec_q, rec_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= LVL_MAX;
      cnt_q   <= '0;
      rec_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;
    if (load_en_i) begin
      level_d = (load_level_i > LVL_MAX) ? LVL_MAX : load_level_i;
      cnt_d   = '0;
      rec_d   = recover_en_i;
    end else if (!halt_i) begin
      rec_d = recover_en_i;
      if (refill_i) begin
        if (level_q < LVL_MAX) level_d = level_q + LEVEL_W'(1);
        cnt_d = '0;
      end else if (recover_en_i != rec_q) begin
        // mode switch: no partial period carries over
        cnt_d = '0;
      end else if (tick_i && recover_en_i) begin
        if (level_q >= LVL_MAX) begin
          cnt_d = '0;
        end else if (cnt_q >= REC_LAST) begin
          level_d = level_q + LEVEL_W'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end else if (tick_i && !hold_i && (level_q != '0)) begin
        if (cnt_q >= DECAY_LAST) begin
          level_d = level_q - LEVEL_W'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/need_level_engine.sv
// Need-level engine top: ms prescaler, sticky death flag, per-channel
// instances and level/flag bus packing.
module need_level_engine
  import pet_pkg::*;
#(
  parameter int unsigned NUM_NEEDS  = 3,
  parameter int unsigned LEVEL_W    = LEVEL_W_DEF,
  parameter int unsigned LEVEL_MAX  = LEVEL_MAX_DEF,
  parameter int unsigned LOW_THRESH = LOW_THRESH_DEF,
  parameter int unsigned TICK_DIV   = TICK_DIV_MS,
  parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
  parameter logic [NUM_NEEDS*PERIOD_W-1:0] DECAY_MS   = {16'd20000, 16'd10000, 16'd40000},
  parameter logic [NUM_NEEDS*PERIOD_W-1:0] RECOVER_MS = {16'd10000, 16'd10000, 16'd10000}
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         freeze_i,
  input  logic [NUM_NEEDS-1:0]         refill_i,
  input  logic [NUM_NEEDS-1:0]         recover_en_i,
  input  logic [NUM_NEEDS-1:0]         hold_i,
  input  logic                         load_en_i,
  input  logic [NUM_NEEDS*LEVEL_W-1:0] load_level_i,
  output logic [NUM_NEEDS*LEVEL_W-1:0] level_o,
  output logic [NUM_NEEDS-1:0]         low_o,
  output logic [NUM_NEEDS-1:0]         empty_o,
  output logic [NUM_NEEDS-1:0]         full_o,
  output logic                         dead_o,
  output logic                         tick_ms_o
);

  localparam int unsigned        PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_LOW  = LEVEL_W'(LOW_THRESH);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             dead_q, dead_d;
  logic             halt_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      dead_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      dead_q <= dead_d;
    end
  end

  // Prescaler wraps every TICK_DIV cycles; the load strobe restarts it.
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (load_en_i) begin
      pre_d = '0;
    end else if (!freeze_i) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_comb begin
    dead_d = load_en_i ? 1'b0 : (dead_q | (|empty_o));
  end

  assign halt_c    = dead_q | freeze_i;
  assign dead_o    = dead_q;
  assign tick_ms_o = tick_q;

  for (genvar i = 0; i < NUM_NEEDS; i++) begin : g_ch
    localparam int unsigned DEC_I = period_field(FIELD_VEC_W'(DECAY_MS), i, PERIOD_W);
    localparam int unsigned REC_I = period_field(FIELD_VEC_W'(RECOVER_MS), i, PERIOD_W);

    need_channel #(
      .LEVEL_W   (LEVEL_W),
      .LEVEL_MAX (LEVEL_MAX),
      .PERIOD_W  (PERIOD_W),
      .DECAY_MS  (DEC_I),
      .RECOVER_MS(REC_I)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .tick_i      (tick_q),
      .halt_i      (halt_c),
      .load_en_i   (load_en_i),
      .load_level_i(load_level_i[i*LEVEL_W +: LEVEL_W]),
      .refill_i    (refill_i[i]),
      .recover_en_i(recover_en_i[i]),
      .hold_i      (hold_i[i]),
      .level_o     (level_o[i*LEVEL_W +: LEVEL_W])
    );

    assign low_o[i]   = (level_o[i*LEVEL_W +: LEVEL_W] <= LVL_LOW);
    assign empty_o[i] = (level_o[i*LEVEL_W +: LEVEL_W] == '0);
    assign full_o[i]  = (level_o[i*LEVEL_W +: LEVEL_W] == LVL_MAX);
  end

endmodule

// File: tb/tb_need_level_engine.sv
// Directed bench for need_level_engine with TICK_DIV=4, DECAY={3,2,4}, RECOVER={2,2,2}.
module tb_need_level_engine;

  logic       clk;
  logic       rst_n;
  logic       freeze;
  logic [2:0] refill, recover_en, hold;
  logic       load_en;
  logic [8:0] load_level;
  logic [8:0] level;
  logic [2:0] low, empty, full;
  logic       dead, tick;

  int errors = 0;
  int checks = 0;
  int t = 0;

  typedef struct packed {
    logic [8:0] ld;
    logic [8:0] lvl;
    logic [2:0] low;
    logic [2:0] emp;
    logic [2:0] full;
    logic       dead;
  } vec_t;

  vec_t vecs [6];

  need_level_engine #(
    .TICK_DIV  (4),
    .DECAY_MS  ({16'd3, 16'd2, 16'd4}),
    .RECOVER_MS({16'd2, 16'd2, 16'd2})
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .freeze_i    (freeze),
    .refill_i    (refill),
    .recover_en_i(recover_en),
    .hold_i      (hold),
    .load_en_i   (load_en),
    .load_level_i(load_level),
    .level_o     (level),
    .low_o       (low),
    .empty_o     (empty),
    .full_o      (full),
    .dead_o      (dead),
    .tick_ms_o   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (t=%0d): got 'h%0h required 'h%0h", name, t, act, exp);
    end
  endtask

  task automatic wait_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  function automatic logic [2:0] chl(input int ch);
    return level[ch*3 +: 3];
  endfunction

  task automatic load(input logic [8:0] v);
    t          = 0;
    load_en    = 1'b1;
    load_level = v;
  endtask

  initial begin
    int highs;
    vecs[0] = '{ld: 9'o555, lvl: 9'o555, low: 3'b000, emp: 3'b000, full: 3'b111, dead: 1'b0};
    vecs[1] = '{ld: 9'o760, lvl: 9'o550, low: 3'b001, emp: 3'b001, full: 3'b110, dead: 1'b1};
    vecs[2] = '{ld: 9'o231, lvl: 9'o231, low: 3'b101, emp: 3'b000, full: 3'b000, dead: 1'b0};
    vecs[3] = '{ld: 9'o045, lvl: 9'o045, low: 3'b100, emp: 3'b100, full: 3'b001, dead: 1'b1};
    vecs[4] = '{ld: 9'o126, lvl: 9'o125, low: 3'b110, emp: 3'b000, full: 3'b001, dead: 1'b0};
    vecs[5] = '{ld: 9'o333, lvl: 9'o333, low: 3'b000, emp: 3'b000, full: 3'b000, dead: 1'b0};

    rst_n = 1'b0; freeze = 1'b0; refill = '0; recover_en = '0; hold = '0;
    load_en = 1'b0; load_level = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t = 0;

    // reset state
    chk("rst_level", 32'(level), 'o555);
    chk("rst_full",  32'(full), 3'b111);
    chk("rst_low",   32'(low), 0);
    chk("rst_empty", 32'(empty), 0);
    chk("rst_dead",  32'(dead), 0);
    chk("rst_tick",  32'(tick), 0);

    // free-running decay from reset
    wait_to(3);  chk("tick_c3", 32'(tick), 0);
    wait_to(4);  chk("tick_c4", 32'(tick), 1);
    wait_to(5);  chk("tick_c5", 32'(tick), 0);
    wait_to(8);  chk("ch1_c8", 32'(chl(1)), 5);
    wait_to(9);  chk("ch1_c9", 32'(chl(1)), 4);
    wait_to(12); chk("ch2_c12", 32'(chl(2)), 5);
    wait_to(13); chk("ch2_c13", 32'(chl(2)), 4);
    wait_to(16); chk("ch0_c16", 32'(chl(0)), 5);
    wait_to(17); chk("lvl_c17", 32'(level), 'o434);
    wait_to(24); chk("low_c24", 32'(low), 3'b000);
    wait_to(25); chk("low_c25", 32'(low), 3'b010);
    chk("lvl_c25", 32'(level), 'o324);
    wait_to(40); chk("lvl_c40", 32'(level), 'o213);
    chk("empty_c40", 32'(empty), 0);
    chk("dead_c40", 32'(dead), 0);
    wait_to(41); chk("lvl_c41", 32'(level), 'o203);
    chk("empty_c41", 32'(empty), 3'b010);
    chk("low_c41", 32'(low), 3'b110);
    chk("dead_c41", 32'(dead), 0);
    wait_to(42); chk("dead_c42", 32'(dead), 1);
    refill = 3'b111;
    wait_to(43); refill = '0;
    wait_to(54); chk("dead_frozen_lvl", 32'(level), 'o203);
    chk("dead_sticky", 32'(dead), 1);

    // load clears dead and restarts the prescaler
    load(9'o551);
    wait_to(1);  load_en = 1'b0;
    chk("ld_lvl", 32'(level), 'o551);
    chk("ld_dead", 32'(dead), 0);
    chk("ld_tick", 32'(tick), 0);
    wait_to(4);  chk("ld_tick4", 32'(tick), 0);
    wait_to(5);  chk("ld_tick5", 32'(tick), 1);
    wait_to(17); chk("ld_ch0_17", 32'(chl(0)), 1);
    wait_to(18); chk("ld_lvl18", 32'(level), 'o430);
    chk("ld_empty18", 32'(empty), 3'b001);
    chk("ld_dead18", 32'(dead), 0);
    wait_to(19); chk("ld_dead19", 32'(dead), 1);

    // recovery on ch0, then hold blocks decay
    load(9'o552); recover_en = 3'b001; hold = 3'b110;
    wait_to(1);  load_en = 1'b0;
    wait_to(9);  chk("rec_ch0_9", 32'(chl(0)), 2);
    wait_to(10); chk("rec_ch0_10", 32'(chl(0)), 3);
    wait_to(18); chk("rec_ch0_18", 32'(chl(0)), 4);
    wait_to(26); chk("rec_lvl26", 32'(level), 'o555);
    chk("rec_full26", 32'(full), 3'b111);
    recover_en = '0; hold = 3'b111;
    wait_to(46); chk("hold_lvl46", 32'(level), 'o555);
    hold = 3'b110;
    wait_to(61); chk("unhold_lvl61", 32'(level), 'o555);
    wait_to(62); chk("unhold_lvl62", 32'(level), 'o554);

    // refill coinciding with decay expiry, and refill restarting the count
    load(9'o355); recover_en = '0; hold = 3'b011;
    wait_to(1);  load_en = 1'b0;
    wait_to(13); chk("rf_ch2_13", 32'(chl(2)), 3);
    refill = 3'b101;
    wait_to(14); refill = '0;
    chk("rf_lvl14", 32'(level), 'o455);
    wait_to(25); chk("rf_ch2_25", 32'(chl(2)), 4);
    wait_to(26); chk("rf_ch2_26", 32'(chl(2)), 3);
    wait_to(31); refill = 3'b100;
    wait_to(32); refill = '0;
    chk("rf_ch2_32", 32'(chl(2)), 4);
    wait_to(38); chk("rf_ch2_38", 32'(chl(2)), 4);
    wait_to(41); chk("rf_ch2_41", 32'(chl(2)), 4);
    wait_to(42); chk("rf_ch2_42", 32'(chl(2)), 3);

    // freeze for 20 cycles
    freeze = 1'b1;
    highs  = 0;
    for (int k = 43; k <= 62; k++) begin
      wait_to(k);
      if (tick) highs++;
    end
    chk("frz_tick_highs", 32'(highs), 0);
    chk("frz_lvl", 32'(level), 'o355);
    freeze = 1'b0;
    wait_to(64); chk("frz_tick64", 32'(tick), 0);
    wait_to(65); chk("frz_tick65", 32'(tick), 1);
    wait_to(73); chk("frz_ch2_73", 32'(chl(2)), 3);
    wait_to(74); chk("frz_ch2_74", 32'(chl(2)), 2);

    // table: load values, clamping and flag decode under freeze
    hold = '0;
    for (int i = 0; i < 6; i++) begin
      freeze     = 1'b1;
      load_en    = 1'b1;
      load_level = vecs[i].ld;
      @(negedge clk);
      load_en = 1'b0;
      chk($sformatf("tbl%0d_lvl", i),   32'(level), 32'(vecs[i].lvl));
      chk($sformatf("tbl%0d_low", i),   32'(low),   32'(vecs[i].low));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
      chk($sformatf("tbl%0d_full", i),  32'(full),  32'(vecs[i].full));
      chk($sformatf("tbl%0d_dead0", i), 32'(dead),  0);
      @(negedge clk);
      chk($sformatf("tbl%0d_dead1", i), 32'(dead),  32'(vecs[i].dead));
    end

    // asynchronous reset mid-count
    freeze = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_arst_lvl", 32'(level), 'o333);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lvl", 32'(level), 'o555);
    chk("arst_full", 32'(full), 3'b111);
    chk("arst_dead", 32'(dead), 0);
    chk("arst_tick", 32'(tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/need_level_engine.md
Name: need_level_engine

Overview:
- Parametrised successor to the pet's central stats logic.
- Maintains NUM_NEEDS independent need levels (energy, hunger, entertainment, …) on a shared millisecond tick.
- Each channel has its own decay and recovery period, refill pulses, hold and test-load.
- Produces level, low, empty and full flags plus a sticky death flag; the pet state FSM consumes these and no longer owns any counters.

Parameters:
- NUM_NEEDS, 3, number of need channels.
- LEVEL_W, 3, bits per level.
- LEVEL_MAX, 5, saturation level and reset value; must be < 2**LEVEL_W.
- LOW_THRESH, 2, low[i] asserts when level <= LOW_THRESH; must be < LEVEL_MAX.
- TICK_DIV, 50000, clk cycles per 1 ms tick; must be >= 1.
- PERIOD_W, 16, bits per period field.
- DECAY_MS, {16'd20000,16'd10000,16'd40000}, packed per-channel decay period in ms; channel 0 is the LSB field; each >= 1.
- RECOVER_MS, {16'd10000,16'd10000,16'd10000}, packed per-channel recovery period in ms; each >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  global pause: levels, channel counters and prescaler hold.
- refill  in  NUM_NEEDS  one-cycle pulse per channel: +1 level, e.g. feed button.
- recover_en  in  NUM_NEEDS  channel is in recovery mode, e.g. sleeping or playing.
- hold  in  NUM_NEEDS  channel decay suspended; recovery unaffected.
- load_en  in  1  test load strobe.
- load_level  in  NUM_NEEDS*LEVEL_W  values written on load_en.
- level  out  NUM_NEEDS*LEVEL_W  current levels, registered.
- low  out  NUM_NEEDS  level <= LOW_THRESH.
- empty  out  NUM_NEEDS  level == 0.
- full  out  NUM_NEEDS  level == LEVEL_MAX.
- dead  out  1  sticky: some channel reached 0.
- tick_ms  out  1  one-cycle pulse per ms, for other blocks.

Behaviour:
- Reset (rst low, asynchronous) clears:
  - prescaler = 0; all channel counters = 0.
  - every level = LEVEL_MAX, dead = 0, tick_ms = 0.
  - Hence low = 0, empty = 0, full = all ones.
- Prescaler:
  - Counts 0..TICK_DIV-1 while freeze = 0.
  - tick_ms is registered high for exactly one cycle when the count wraps.
  - Holds while freeze = 1.
- Per-channel priority, evaluated every clock, highest first:
  - (1) load_en: level = min(load_level[i], LEVEL_MAX); counter = 0.
  - (2) dead or freeze: hold everything.
  - (3) refill[i]: level = level+1, saturating at LEVEL_MAX; counter = 0. Takes effect on the next edge, independent of tick.
  - (4) recover_en[i] on tick_ms:
    - If level < LEVEL_MAX: counter increments; when it reaches RECOVER_MS[i]-1, level +1 and counter = 0.
    - At LEVEL_MAX the counter is held at 0.
  - (5) !hold[i] && !recover_en[i] on tick_ms with level > 0: counter increments; when it reaches DECAY_MS[i]-1, level -1 and counter = 0.
  - (6) Otherwise hold.
- A change in recover_en[i] clears channel i's counter on that edge, so no partial period carries across a mode switch.
- load_en also clears the prescaler and dead.
- Dead:
  - Set on the edge after any level is registered as 0, with load_en low.
  - Once set, only reset or load_en clears it.
  - Loading a 0 level sets dead again one cycle later.
- Latency:
  - level updates are visible one cycle after the causing edge.
  - low, empty and full are combinational from the level register.
  - dead lags empty by one cycle.
- Arithmetic:
  - Counters are PERIOD_W bits.
  - Level math never wraps: increments saturate at LEVEL_MAX and decrements stop at 0.
- Simultaneous refill and decay-expiry on the same cycle: refill wins, giving a net +1, and the counter restarts.

Decomposition:
- Shared package (pet_pkg) holds:
  - LEVEL_W, LEVEL_MAX and LOW_THRESH defaults.
  - The ms tick constant.
  - The state codes used by the FSM.
  - A function that extracts PERIOD_W field i from a packed vector.
- Sub-module need_channel holds one counter and one level with the priority logic above; it is instantiated NUM_NEEDS times via generate.
- The top level holds the prescaler, the dead register and the bus packing.

Test Plan:
Bench parameters: TICK_DIV=4, DECAY_MS={3,2,4}, RECOVER_MS={2,2,2}.
- Reset release, no inputs: levels 5,5,5; full=111. The ch1 level reaches 4 after 2 ticks (8 cycles), and ch0 after 4 ticks.
- Run until ch1 reaches 0 (10 ticks): empty[1]=1 and low[1] rises at level 2. dead=1 on the next cycle; levels then freeze despite ticks and refill.
- load_en with {5,5,1}: levels 5,5,1 next cycle, dead=0, prescaler restarts. ch0 reaches 0 after 4 more ticks, then dead asserts.
- recover_en[0]=1 at ch0 level 2: ch0 goes 3→4→5 at one step per 2 ticks, then holds at 5 with full[0]=1. hold[0]=1 blocks decay after recover_en drops.
- refill[2] pulsed on the cycle its decay counter expires at level 3: level goes to 4, not 2 and not 3.
- freeze=1 for 20 cycles: tick_ms stays low and levels and counters stay unchanged. Asserting rst mid-count restores 5,5,5 asynchronously.
